// File: rtl/call_stack.sv
// Return-address LIFO for JSB/RET: pushes PC+1, exposes the top entry to the PC mux,
// tracks occupancy and latches sticky overflow/underflow for debug.
module call_stack #(
  parameter int ADDR_WIDTH = 12,
  parameter int DEPTH      = 8,
  parameter int CNT_WIDTH  = $clog2(DEPTH) + 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  push_stack,
  input  logic                  pop_stack,
  input  logic                  flush,
  input  logic [ADDR_WIDTH-1:0] ret_addr_in,
  output logic [ADDR_WIDTH-1:0] top_out,
  output logic [CNT_WIDTH-1:0]  count,
  output logic                  empty,
  output logic                  full,
  output logic                  overflow,
  output logic                  underflow
);

  localparam int IDX_W = $clog2(DEPTH);
  localparam logic [CNT_WIDTH-1:0] FULL_CNT = CNT_WIDTH'(DEPTH);

  logic [ADDR_WIDTH-1:0] mem_q [DEPTH];
  logic [CNT_WIDTH-1:0]  sp_q, sp_d;
  logic                  ovf_q, ovf_d;
  logic                  unf_q, unf_d;
  logic                  wr_en;
  logic [IDX_W-1:0]      wr_idx;
  logic [IDX_W-1:0]      top_idx;
  logic                  is_empty, is_full;

  assign is_empty = (sp_q == '0);
  assign is_full  = (sp_q == FULL_CNT);
  // Low bits of sp wrap DEPTH to 0, so subtracting one lands on DEPTH-1 when full.
  assign top_idx  = sp_q[IDX_W-1:0] - IDX_W'(1);

  assign top_out   = is_empty ? '0 : mem_q[top_idx];
  assign count     = sp_q;
  assign empty     = is_empty;
  assign full      = is_full;
  assign overflow  = ovf_q;
  assign underflow = unf_q;

  always_comb begin
    sp_d   = sp_q;
    ovf_d  = ovf_q;
    unf_d  = unf_q;
    wr_en  = 1'b0;
    wr_idx = sp_q[IDX_W-1:0];
    if (flush) begin
      sp_d  = '0;
      ovf_d = 1'b0;
      unf_d = 1'b0;
    end else if (push_stack && pop_stack) begin
      wr_en = 1'b1;
      if (is_empty) begin
        wr_idx = '0;
        sp_d   = CNT_WIDTH'(1);
      end else begin
        wr_idx = top_idx;
      end
    end else if (push_stack) begin
      if (is_full) begin
        ovf_d = 1'b1;
      end else begin
        wr_en = 1'b1;
        sp_d  = sp_q + CNT_WIDTH'(1);
      end
    end else if (pop_stack) begin
      if (is_empty) begin
        unf_d = 1'b1;
      end else begin
        sp_d = sp_q - CNT_WIDTH'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sp_q  <= '0;
      ovf_q <= 1'b0;
      unf_q <= 1'b0;
    end else begin
      sp_q  <= sp_d;
      ovf_q <= ovf_d;
      unf_q <= unf_d;
    end
  end

  // Entry storage is never cleared; validity comes solely from sp.
  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wr_idx] <= ret_addr_in;
  end

endmodule

// File: tb/tb_call_stack.sv
// Directed and randomized checks of call_stack against a queue-based LIFO model.
module tb_call_stack;

  localparam int AW    = 12;
  localparam int DEPTH = 8;
  localparam int CW    = $clog2(DEPTH) + 1;

  logic          clk = 1'b0;
  logic          rst;
  logic          push_stack, pop_stack, flush;
  logic [AW-1:0] ret_addr_in;
  logic [AW-1:0] top_out;
  logic [CW-1:0] count;
  logic          empty, full, overflow, underflow;

  int checks = 0;
  int errors = 0;

  logic [AW-1:0] q[$];
  bit            m_ovf, m_unf;

  call_stack #(.ADDR_WIDTH(AW), .DEPTH(DEPTH), .CNT_WIDTH(CW)) dut (
    .clk(clk), .rst(rst), .push_stack(push_stack), .pop_stack(pop_stack),
    .flush(flush), .ret_addr_in(ret_addr_in), .top_out(top_out), .count(count),
    .empty(empty), .full(full), .overflow(overflow), .underflow(underflow)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [AW-1:0] m_top();
    return (q.size() == 0) ? '0 : q[q.size()-1];
  endfunction

  task automatic chk_all(input string tag);
    chk({tag, ".count"},     32'(count),     32'(q.size()));
    chk({tag, ".empty"},     32'(empty),     32'(q.size() == 0));
    chk({tag, ".full"},      32'(full),      32'(q.size() == DEPTH));
    chk({tag, ".top"},       32'(top_out),   32'(m_top()));
    chk({tag, ".overflow"},  32'(overflow),  32'(m_ovf));
    chk({tag, ".underflow"}, 32'(underflow), 32'(m_unf));
  endtask

  function automatic void model(input bit pu, input bit po, input bit fl, input logic [AW-1:0] a);
    if (fl) begin
      q.delete();
      m_ovf = 0;
      m_unf = 0;
    end else if (pu && po) begin
      if (q.size() == 0) q.push_back(a);
      else q[q.size()-1] = a;
    end else if (pu) begin
      if (q.size() == DEPTH) m_ovf = 1;
      else q.push_back(a);
    end else if (po) begin
      if (q.size() == 0) m_unf = 1;
      else void'(q.pop_back());
    end
  endfunction

  task automatic step(input string tag, input bit pu, input bit po, input bit fl, input logic [AW-1:0] a);
    push_stack  = pu;
    pop_stack   = po;
    flush       = fl;
    ret_addr_in = a;
    @(posedge clk);
    #1;
    model(pu, po, fl, a);
    push_stack = 0;
    pop_stack  = 0;
    flush      = 0;
    chk_all(tag);
  endtask

  task automatic model_reset();
    q.delete();
    m_ovf = 0;
    m_unf = 0;
  endtask

  initial begin
    rst = 1; push_stack = 0; pop_stack = 0; flush = 0; ret_addr_in = '0;
    model_reset();
    #12;
    chk_all("reset");
    rst = 0;
    for (int i = 0; i < 3; i++) step("idle", 0, 0, 0, '0);

    step("lifo_push", 1, 0, 0, 12'h010);
    step("lifo_push", 1, 0, 0, 12'h020);
    step("lifo_push", 1, 0, 0, 12'h030);
    chk("lifo_top3", 32'(top_out), 32'h030);
    for (int i = 0; i < 3; i++) step("lifo_pop", 0, 1, 0, '0);
    chk("lifo_empty", 32'(empty), 32'd1);

    for (int i = 1; i <= 9; i++) begin
      step("fill", 1, 0, 0, AW'(12'h100 + i));
      if (i == 8) chk("fill_full", 32'(full), 32'd1);
    end
    chk("ovf_top", 32'(top_out), 32'h108);
    chk("ovf_flag", 32'(overflow), 32'd1);
    for (int i = 0; i < 8; i++) step("drain", 0, 1, 0, '0);

    step("flush_a", 0, 0, 1, '0);
    step("unf_pop", 0, 1, 0, '0);
    chk("unf_flag", 32'(underflow), 32'd1);
    step("unf_push", 1, 0, 0, 12'h055);
    chk("unf_push_top", 32'(top_out), 32'h055);
    step("unf_flush", 0, 0, 1, '0);
    chk("unf_cleared", 32'(underflow), 32'd0);

    step("rep_push", 1, 0, 0, 12'h011);
    step("rep_push", 1, 0, 0, 12'h022);
    step("replace", 1, 1, 0, 12'h0AA);
    chk("replace_top", 32'(top_out), 32'h0AA);
    step("rep_pop", 0, 1, 0, '0);
    chk("rep_expose", 32'(top_out), 32'h011);
    step("flush_b", 1, 1, 1, 12'h3FF);
    step("pushpop_empty", 1, 1, 0, 12'h123);

    step("ar_push", 1, 0, 0, 12'h077);
    #3 rst = 1;
    #1;
    model_reset();
    chk_all("async_rst");
    #2 rst = 0;
    step("post_rst", 1, 0, 0, 12'h0BC);
    step("post_rst", 1, 0, 0, 12'h0DE);

    for (int i = 0; i < 400; i++) begin
      bit pu, po, fl;
      pu = ($urandom_range(0, 99) < 50);
      po = ($urandom_range(0, 99) < 40);
      fl = ($urandom_range(0, 99) < 3);
      step("rand", pu, po, fl, AW'($urandom));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
